mfcc_frame: RTL and testbench
=============================

MFCC_FRAME -- requirements
Module: mfcc_frame

Interface
REQ-001 The block SHALL have the parameter N_MEL, default 26: number of mel bands (2..64).
REQ-002 The block SHALL have the parameter N_CEP, default 13: number of cepstral coefficients (1..N_MEL).
REQ-003 The block SHALL have the parameter IN_W, default 32: unsigned band-energy sample width.
REQ-004 The block SHALL have the parameter COEF_W, default 16: signed DCT coefficient width, Q1.(COEF_W-1).
REQ-005 The block SHALL have the parameter FRAC_W, default 8: fractional bits of the log2 value.
REQ-006 The block SHALL have the parameter OUT_W, default 32: signed output coefficient width.
REQ-007 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  energy sample valid.
- in_ready  out  1  block accepts a sample.
- in_band  in  clog2(N_MEL)  target mel band.
- in_data  in  IN_W  unsigned weighted energy.
- in_last  in  1  last sample of frame.
- cfg_we  in  1  DCT table write strobe.
- cfg_addr  in  clog2(N_CEP*N_MEL)  table address = k*N_MEL+j.
- cfg_data  in  COEF_W  signed coefficient.
- out_valid  out  1  coefficient valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  signed MFCC coefficient.
- out_idx  out  clog2(N_CEP)  coefficient index k.
- out_last  out  1  marks k = N_CEP-1.
- busy  out  1  high in any state other than ACCUM.
- ovf  out  1  sticky: an accumulator or output saturated in the current frame.

Function
REQ-008 The block SHALL implement the states ACCUM, LOG, DCT and OUT, with ACCUM as the reset state.
REQ-009 In ACCUM, in_ready SHALL be 1 and it SHALL be 0 in every other state; a transfer occurs on in_valid&&in_ready.
REQ-010 On a transfer, acc[in_band] SHALL increase by in_data, saturating at 2^(IN_W+8)-1 and setting ovf on saturation.
REQ-011 On a transfer with in_band >= N_MEL, the sample SHALL be consumed with no accumulator change.
REQ-012 A transfer with in_last=1 SHALL be accumulated, and the state SHALL be LOG on the next cycle.
REQ-013 LOG SHALL take exactly N_MEL cycles, processing one band per cycle: L[j] = p<<FRAC_W | m, unsigned.
- p is the leading-one position of acc[j].
- m is the FRAC_W bits immediately below the leading one, zero-padded if fewer exist.
- acc[j] = 0 SHALL give L[j] = 0.
REQ-014 DCT SHALL compute coefficient k using one MAC per cycle over N_MEL cycles: S = sum over j of L[j]*C[k][j], signed, at full precision.
REQ-015 The output SHALL be S arithmetic-shifted right by COEF_W-1 (floor), then saturated to OUT_W; saturation SHALL set ovf.
REQ-016 After the last MAC, the state SHALL be OUT with out_valid=1 and out_data, out_idx=k and out_last=(k==N_CEP-1), all stable until out_ready.
REQ-017 On out_valid&&out_ready with k<N_CEP-1, the state SHALL return to DCT for k+1.
REQ-018 On out_valid&&out_ready with k=N_CEP-1, the state SHALL be ACCUM on the next cycle, with all acc cleared and ovf cleared.
REQ-019 Latency from the in_last transfer to the first out_valid SHALL be N_MEL+N_MEL+1 cycles, and each subsequent coefficient SHALL appear N_MEL+1 cycles after the previous handshake.
REQ-020 Config writes SHALL take effect only in ACCUM; cfg_we in any other state SHALL be ignored.
REQ-021 A config write SHALL be visible to the next frame's DCT.
REQ-022 A config write with cfg_addr >= N_CEP*N_MEL SHALL be ignored.
REQ-023 A simultaneous config write and sample transfer in ACCUM SHALL both take effect.
REQ-024 The DCT table SHALL NOT be reset.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously enter ACCUM with acc=0, L=0, ovf=0, out_valid=0, out_data=0, out_idx=0, out_last=0 and busy=0.
REQ-026 After reset is released, in_ready SHALL be 1 from the first clock edge.
REQ-027 A reset asserted mid-LOG, mid-DCT or mid-OUT SHALL abort the frame with no further out_valid.

Verification
REQ-028 The bench SHALL cover the uniform frame: all C=16384, N_MEL samples of 256 to bands 0..25 with the last flagged -> each L=2048, and out_data=26624 for k=0..12 with out_last only at k=12.
REQ-029 The bench SHALL cover log edge values: band energies 0, 1 and 3 -> L = 0, 0 and 384 respectively.
REQ-030 The bench SHALL cover backpressure: out_ready held 0 for 10 cycles at k=4 -> out_data and out_idx stable, in_ready=0, and no sample lost.
REQ-031 The bench SHALL cover saturation: 300 samples of 2^32-1 to band 0 -> acc[0] pins at 2^40-1 and ovf=1 until the final handshake.
REQ-032 The bench SHALL cover config gating and invalid bands: cfg_we during DCT with a changed value -> current frame unchanged; in_band=30 -> frame result unaffected.
REQ-033 The bench SHALL cover reset mid-DCT: rst_n pulsed low at DCT k=2 -> out_valid=0 immediately, next frame correct with table retained.

Source files
------------

// File: rtl/mfcc_frame.sv
// MFCC frame back end: accumulates weighted mel-band energies, converts each band
// to fixed-point log2, then streams N_CEP DCT coefficients over a ready/valid port.
module mfcc_frame #(
  parameter int N_MEL  = 26,
  parameter int N_CEP  = 13,
  parameter int IN_W   = 32,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [$clog2(N_MEL)-1:0]         in_band,
  input  logic [IN_W-1:0]                  in_data,
  input  logic                             in_last,
  input  logic                             cfg_we,
  input  logic [$clog2(N_CEP*N_MEL)-1:0]   cfg_addr,
  input  logic signed [COEF_W-1:0]         cfg_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [OUT_W-1:0]          out_data,
  output logic [$clog2(N_CEP)-1:0]         out_idx,
  output logic                             out_last,
  output logic                             busy,
  output logic                             ovf
);

  localparam int BAND_W = $clog2(N_MEL);
  localparam int N_COEF = N_CEP * N_MEL;
  localparam int ADDR_W = $clog2(N_COEF);
  localparam int IDX_W  = $clog2(N_CEP);
  localparam int ACC_W  = IN_W + 8;
  localparam int P_W    = $clog2(ACC_W);
  localparam int L_W    = P_W + FRAC_W;
  localparam int S_W    = L_W + 1 + COEF_W + $clog2(N_MEL);
  localparam int SH_W   = S_W - (COEF_W - 1);
  localparam int EXT_W  = ((SH_W > OUT_W) ? SH_W : OUT_W) + 1;
  localparam int CNT_W  = $clog2(N_MEL + 1);

  typedef enum logic [1:0] {ST_ACCUM, ST_LOG, ST_DCT, ST_OUT} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         k_q, k_d;
  logic [ACC_W-1:0]         acc_q [N_MEL];
  logic [ACC_W-1:0]         acc_d [N_MEL];
  logic [L_W-1:0]           l_q [N_MEL];
  logic [L_W-1:0]           l_d [N_MEL];
  logic signed [S_W-1:0]    sum_q, sum_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     ovf_q, ovf_d;

  logic signed [COEF_W-1:0] coef_mem [N_COEF];
  logic                     mem_we;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [COEF_W-1:0] coef_rd;
  logic [BAND_W-1:0]        band_idx;
  logic signed [S_W-1:0]    prod;
  logic [ACC_W:0]           acc_sum;
  logic signed [EXT_W-1:0]  sh_ext, max_v, min_v;

  // Leading-one position in the integer bits; appending FRAC_W zeros before the
  // shift pads the mantissa when fewer than FRAC_W bits sit below the leading one.
  function automatic logic [L_W-1:0] log2_fx(input logic [ACC_W-1:0] a);
    logic [P_W-1:0]          p;
    logic [ACC_W+FRAC_W-1:0] ext;
    p = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (a[i]) p = P_W'(i);
    end
    ext = {a, FRAC_W'(0)} >> p;
    log2_fx = (a == '0) ? '0 : {p, ext[FRAC_W-1:0]};
  endfunction

  assign band_idx = cnt_q[BAND_W-1:0];
  assign rd_addr  = ADDR_W'(k_q) * ADDR_W'(N_MEL) + ADDR_W'(cnt_q);
  assign coef_rd  = coef_mem[rd_addr];
  assign prod     = S_W'($signed({1'b0, l_q[band_idx]})) * S_W'(coef_rd);
  assign acc_sum  = {1'b0, acc_q[in_band]} + (ACC_W+1)'(in_data);
  assign sh_ext   = EXT_W'(sum_q >>> (COEF_W - 1));
  assign max_v    = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign min_v    = ~max_v;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    acc_d      = acc_q;
    l_d        = l_q;
    sum_d      = sum_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        mem_we = cfg_we && ({1'b0, cfg_addr} < (ADDR_W+1)'(N_COEF));
        if (in_valid) begin
          if ({1'b0, in_band} < (BAND_W+1)'(N_MEL)) begin
            if (acc_sum[ACC_W]) begin
              acc_d[in_band] = '1;
              ovf_d          = 1'b1;
            end else begin
              acc_d[in_band] = acc_sum[ACC_W-1:0];
            end
          end
          if (in_last) begin
            state_d = ST_LOG;
            cnt_d   = '0;
          end
        end
      end
      ST_LOG: begin
        l_d[band_idx] = log2_fx(acc_q[band_idx]);
        if (cnt_q == CNT_W'(N_MEL - 1)) begin
          state_d = ST_DCT;
          cnt_d   = '0;
          sum_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DCT: begin
        // N_MEL MAC cycles, then one cycle to scale and saturate the sum.
        if (cnt_q == CNT_W'(N_MEL)) begin
          state_d = ST_OUT;
          if (sh_ext > max_v) begin
            out_data_d = {1'b0, {(OUT_W-1){1'b1}}};
            ovf_d      = 1'b1;
          end else if (sh_ext < min_v) begin
            out_data_d = {1'b1, {(OUT_W-1){1'b0}}};
            ovf_d      = 1'b1;
          end else begin
            out_data_d = sh_ext[OUT_W-1:0];
          end
        end else begin
          sum_d = sum_q + prod;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (k_q == IDX_W'(N_CEP - 1)) begin
            state_d = ST_ACCUM;
            k_d     = '0;
            acc_d   = '{default: '0};
            ovf_d   = 1'b0;
          end else begin
            state_d = ST_DCT;
            k_d     = k_q + IDX_W'(1);
            cnt_d   = '0;
            sum_d   = '0;
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      cnt_q      <= '0;
      k_q        <= '0;
      acc_q      <= '{default: '0};
      l_q        <= '{default: '0};
      sum_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      l_q        <= l_d;
      sum_q      <= sum_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: the coefficient table has no reset; it is configuration that must survive
  // a frame abort, and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) coef_mem[cfg_addr] <= cfg_data;
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign busy      = (state_q != ST_ACCUM);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign out_idx   = k_q;
  assign out_last  = out_valid && (k_q == IDX_W'(N_CEP - 1));
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mfcc_frame.sv
// Self-checking bench for mfcc_frame: constant vector tables for the uniform and
// log-edge frames, a behavioural model feeding a scoreboard queue for the rest.
module tb_mfcc_frame;

  localparam int N_MEL  = 26;
  localparam int N_CEP  = 13;
  localparam int IN_W   = 32;
  localparam int COEF_W = 16;
  localparam int FRAC_W = 8;
  localparam int OUT_W  = 32;
  localparam int BAND_W = $clog2(N_MEL);
  localparam int N_COEF = N_CEP * N_MEL;
  localparam int ADDR_W = $clog2(N_COEF);
  localparam int IDX_W  = $clog2(N_CEP);
  localparam longint ACC_MAX = (64'sd1 <<< (IN_W + 8)) - 1;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid, in_ready, in_last;
  logic [BAND_W-1:0]        in_band;
  logic [IN_W-1:0]          in_data;
  logic                     cfg_we;
  logic [ADDR_W-1:0]        cfg_addr;
  logic signed [COEF_W-1:0] cfg_data;
  logic                     out_valid, out_ready, out_last, busy, ovf;
  logic signed [OUT_W-1:0]  out_data;
  logic [IDX_W-1:0]         out_idx;

  mfcc_frame #(
    .N_MEL(N_MEL), .N_CEP(N_CEP), .IN_W(IN_W),
    .COEF_W(COEF_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_band(in_band),
    .in_data(in_data), .in_last(in_last),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [OUT_W-1:0] data;
    int                      idx;
    bit                      last;
  } exp_t;

  typedef struct {
    int     band;
    longint energy;
    int     want_l;
  } vec_t;

  exp_t                     sb[$];
  vec_t                     vecs[8];
  logic signed [COEF_W-1:0] tb_c [N_CEP][N_MEL];
  longint                   tb_acc [N_MEL];
  longint                   t_ref;
  int                       n_checks = 0;
  int                       n_errors = 0;

  task automatic check(input string name, input longint act, input longint want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int log_model(input longint a);
    int     p;
    longint m;
    if (a == 0) return 0;
    p = 0;
    for (int i = 0; i < IN_W + 8; i++) if (a[i]) p = i;
    if (p >= FRAC_W) m = (a >> (p - FRAC_W)) & ((64'sd1 <<< FRAC_W) - 1);
    else             m = (a << (FRAC_W - p)) & ((64'sd1 <<< FRAC_W) - 1);
    return p * (1 << FRAC_W) + int'(m);
  endfunction

  task automatic push_model_frame();
    int     l [N_MEL];
    longint s, o;
    exp_t   e;
    for (int j = 0; j < N_MEL; j++) l[j] = log_model(tb_acc[j]);
    for (int k = 0; k < N_CEP; k++) begin
      s = 0;
      for (int j = 0; j < N_MEL; j++) s += longint'(l[j]) * longint'(tb_c[k][j]);
      o = s >>> (COEF_W - 1);
      if (o > 64'sd2147483647) o = 64'sd2147483647;
      if (o < -64'sd2147483648) o = -64'sd2147483648;
      e.data = OUT_W'(o);
      e.idx  = k;
      e.last = (k == N_CEP - 1);
      sb.push_back(e);
    end
  endtask

  task automatic push_const(input int k, input longint v);
    exp_t e;
    e.data = OUT_W'(v);
    e.idx  = k;
    e.last = (k == N_CEP - 1);
    sb.push_back(e);
  endtask

  // All tasks start just after a falling edge and end just after one.
  task automatic cfg_write(input int addr, input int data, input bit effective);
    cfg_we   = 1'b1;
    cfg_addr = ADDR_W'(addr);
    cfg_data = COEF_W'(data);
    @(negedge clk);
    cfg_we = 1'b0;
    if (effective && addr < N_COEF) tb_c[addr / N_MEL][addr % N_MEL] = COEF_W'(data);
  endtask

  task automatic load_table(input int mode);
    int v;
    for (int k = 0; k < N_CEP; k++) begin
      for (int j = 0; j < N_MEL; j++) begin
        case (mode)
          0:       v = 16384;
          1:       v = (j == k && k < 8) ? -32768 : 0;
          default: v = int'($urandom_range(0, 65535));
        endcase
        cfg_write(k * N_MEL + j, v, 1'b1);
      end
    end
  endtask

  task automatic send(input int band, input longint data, input bit last, input bit model,
                      input bit do_cfg = 1'b0, input int caddr = 0, input int cdata = 0);
    in_valid = 1'b1;
    in_band  = BAND_W'(band);
    in_data  = IN_W'(data);
    in_last  = last;
    if (do_cfg) begin
      cfg_we   = 1'b1;
      cfg_addr = ADDR_W'(caddr);
      cfg_data = COEF_W'(cdata);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    cfg_we   = 1'b0;
    if (do_cfg) tb_c[caddr / N_MEL][caddr % N_MEL] = COEF_W'(cdata);
    if (band < N_MEL) begin
      tb_acc[band] += data;
      if (tb_acc[band] > ACC_MAX) tb_acc[band] = ACC_MAX;
    end
    if (last) begin
      t_ref = cyc;
      if (model) push_model_frame();
    end
  endtask

  task automatic collect(input int n_out, input int stall_k, input int stall_n,
                         input bit hold, input bit want_ovf);
    longint lat_want = 2 * N_MEL + 1;
    int     waited;
    exp_t   e;
    for (int i = 0; i < n_out; i++) begin
      waited = 0;
      while (!out_valid && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!out_valid) begin
        check("out_valid_timeout", 0, 1);
        return;
      end
      if (sb.size() == 0) begin
        check("scoreboard_empty", 0, 1);
        return;
      end
      e = sb.pop_front();
      check("latency", cyc - t_ref, lat_want);
      check("out_data", out_data, e.data);
      check("out_idx", out_idx, e.idx);
      check("out_last", out_last, e.last);
      check("busy_in_out", busy, 1);
      check("in_ready_in_out", in_ready, 0);
      check("ovf_in_out", ovf, want_ovf);
      if (i == stall_k) begin
        if (hold) begin
          in_valid = 1'b1;
          in_band  = BAND_W'(3);
          in_data  = IN_W'(1000);
          in_last  = 1'b0;
        end
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, e.data);
          check("stall_idx", out_idx, e.idx);
          check("stall_in_ready", in_ready, 0);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      t_ref     = cyc;
      lat_want  = N_MEL + 1;
    end
    if (n_out == N_CEP) begin
      check("busy_after_frame", busy, 0);
      check("ovf_after_frame", ovf, 0);
      check("out_valid_after_frame", out_valid, 0);
      for (int j = 0; j < N_MEL; j++) tb_acc[j] = 0;
      if (hold) begin
        check("held_sample_ready", in_ready, 1);
        @(negedge clk);
        in_valid   = 1'b0;
        tb_acc[3] += 1000;
      end
    end
  endtask

  task automatic random_samples(input int n);
    for (int i = 0; i < n; i++) send(int'($urandom_range(0, N_MEL - 1)), longint'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int     seen;
    int     edit_addr;
    int     edit_val;
    vecs[0] = '{band: 0, energy: 0,             want_l: 0};
    vecs[1] = '{band: 1, energy: 1,             want_l: 0};
    vecs[2] = '{band: 2, energy: 3,             want_l: 384};
    vecs[3] = '{band: 3, energy: 256,           want_l: 2048};
    vecs[4] = '{band: 4, energy: 5,             want_l: 576};
    vecs[5] = '{band: 5, energy: 1000,          want_l: 2548};
    vecs[6] = '{band: 6, energy: 64'h80000000,  want_l: 7936};
    vecs[7] = '{band: 7, energy: 64'hFFFFFFFF,  want_l: 8191};
    for (int j = 0; j < N_MEL; j++) tb_acc[j] = 0;

    rst_n = 1'b0; in_valid = 1'b0; in_band = '0; in_data = '0; in_last = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b0; t_ref = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    // Uniform frame: every band L=2048, every coefficient 26*2048*0.5 = 26624.
    load_table(0);
    for (int j = 0; j < N_MEL; j++) send(j, 256, j == N_MEL - 1, 1'b0);
    for (int k = 0; k < N_CEP; k++) push_const(k, 26624);
    collect(N_CEP, -1, 0, 1'b0, 1'b0);

    // Log edge values: diagonal -1.0 table makes out_data[k] = -L[k].
    load_table(1);
    for (int i = 0; i < 8; i++) send(vecs[i].band, vecs[i].energy, i == 7, 1'b0);
    for (int k = 0; k < N_CEP; k++) push_const(k, (k < 8) ? -longint'(vecs[k].want_l) : 0);
    collect(N_CEP, -1, 0, 1'b0, 1'b0);

    // Backpressure at k=4 with a sample held on the input throughout.
    load_table(2);
    random_samples(40);
    send(int'($urandom_range(0, N_MEL - 1)), longint'($urandom), 1'b1, 1'b1);
    collect(N_CEP, 4, 10, 1'b1, 1'b0);

    // Held sample lands in this frame; invalid band, concurrent cfg write, gated cfg write.
    edit_addr = 5 * N_MEL;
    edit_val  = int'(tb_c[5][0]) ^ 16'h4000;
    random_samples(10);
    send(0, 12345, 1'b0, 1'b0);
    send(30, 64'hFFFFFFFF, 1'b0, 1'b0);
    send(1, 777, 1'b0, 1'b0, 1'b1, 7 * N_MEL + 3, int'($urandom_range(0, 65535)));
    send(N_MEL - 1, longint'($urandom), 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    check("busy_in_dct", busy, 1);
    cfg_write(edit_addr, edit_val, 1'b0);
    collect(N_CEP, -1, 0, 1'b0, 1'b0);

    // Same edit in ACCUM takes effect; out-of-range write ignored; saturation frame.
    cfg_write(edit_addr, edit_val, 1'b1);
    cfg_write(N_COEF + 3, 777, 1'b1);
    for (int i = 0; i < 300; i++) begin
      send(0, 64'hFFFFFFFF, i == 299, 1'b1);
      if (i == 255) check("ovf_before_sat", ovf, 0);
      if (i == 256) check("ovf_at_sat", ovf, 1);
    end
    check("ovf_after_sat", ovf, 1);
    collect(N_CEP, -1, 0, 1'b0, 1'b1);

    // Reset pulsed during DCT for k=2 aborts the frame; table survives.
    random_samples(20);
    send(int'($urandom_range(0, N_MEL - 1)), longint'($urandom), 1'b1, 1'b1);
    collect(2, -1, 0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_out_idx", out_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int j = 0; j < N_MEL; j++) tb_acc[j] = 0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", seen, 0);
    check("abort_in_ready", in_ready, 1);
    random_samples(15);
    send(int'($urandom_range(0, N_MEL - 1)), longint'($urandom), 1'b1, 1'b1);
    collect(N_CEP, -1, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
